// File: rtl/uart_frame_rx.sv
// Oversampling serial receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop.
// Presents each good frame on a valid/ready holding register; flags framing errors and overruns.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | qualifying the start bit at mid-bit
// DATA      | sampling 8 data bits
// PARITY    | sampling the raw parity bit
// STOP      | sampling stop bit, deliver / overrun / frame error
// WAIT_HIGH | after a bad stop, wait for the line to return high
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data_out,
  output logic       parity_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             par_bit;
  logic             cnt_clr, shift_en, par_en, load, ferr_set, ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    load      = 1'b0;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            // a held, unaccepted frame wins over the new one
            if (!valid || ready) load = 1'b1;
            else                 ovr_set = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      parity_out <= 1'b0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (state != DATA) idx <= '0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en) shift[idx] <= rx_s;
      if (par_en) par_bit <= rx_s;
      if (load) begin
        data_out   <= shift;
        parity_out <= par_bit;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      frame_err <= ferr_set;
      overrun   <= ovr_set;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed and randomized frames for uart_frame_rx, checked against a frame-level
// model of the holding register (delivered stream, error and overrun counts).
module tb_uart_frame_rx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n, rx, ready;
  logic [7:0] data_out;
  logic       parity_out, valid, frame_err, overrun;

  uart_frame_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .ready(ready),
    .data_out(data_out), .parity_out(parity_out), .valid(valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed side: accepted frames, pulse counts and valid edges
  logic [8:0] got_mem [0:255];
  int   got_n = 0, ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0;
  int   rise_cyc = 0, fall_cyc = 0;
  logic valid_d = 1'b0;

  always @(negedge clk) begin
    if (valid && ready && got_n < 256) begin
      got_mem[got_n] = {parity_out, data_out};
      got_n++;
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (valid && !valid_d) rise_cyc = cyc;
    if (!valid && valid_d) fall_cyc = cyc;
    valid_d = valid;
  end

  // expected side
  logic [8:0] exp_mem [0:255];
  int   exp_n = 0, exp_ferr = 0, exp_ovr = 0;
  logic m_held = 1'b0;
  int   checks = 0, failures = 0;
  int   last_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop);
    if (!stop) exp_ferr++;
    else if (m_held && !ready) exp_ovr++;
    else begin
      exp_mem[exp_n] = {p, d};
      exp_n++;
      m_held = !ready;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    model_frame(d, p, stop);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic set_ready(input logic b);
    @(posedge clk);
    #2 ready = b;
    if (b) m_held = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   f0, o0, n0;
    logic [7:0] d;
    logic p, st;

    rst_n = 1'b0; rx = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_parity", parity_out, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(2 * C);

    // single frame, exact latency and one-cycle valid with ready high
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2 * C);
    check("a5_rise_cyc", rise_cyc, last_start + 45);
    check("a5_pulse_len", fall_cyc - rise_cyc, 1);
    check("a5_data", got_mem[got_n-1], {1'b0, 8'hA5});

    // one-cycle glitch; a real start 3 cycles later must still be caught on time
    f0 = ferr_cnt; n0 = got_n;
    rx = 1'b0; @(negedge clk);
    rx = 1'b1; repeat (2) @(negedge clk);
    send_frame(8'h96, 1'b1, 1'b1);
    idle(2 * C);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_frames", got_n - n0, 1);
    check("glitch_rise_cyc", rise_cyc, last_start + 45);

    // bad stop, line held low, then a good frame
    f0 = ferr_cnt; n0 = got_n;
    send_frame(8'h5A, 1'b0, 1'b0);
    rx = 1'b0; repeat (3 * C) @(negedge clk);
    idle(C);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(2 * C);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_frames", got_n - n0, 1);
    check("ferr_next_data", got_mem[got_n-1], {1'b0, 8'h3C});

    // overrun with ready low
    o0 = ovr_cnt;
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(2 * C);
    check("ovr_count", ovr_cnt - o0, 1);
    check("ovr_hold_data", data_out, 8'h11);
    check("ovr_hold_par", parity_out, 1);
    check("ovr_hold_valid", valid, 1);
    @(posedge clk);
    #2 ready = 1'b1;
    m_held = 1'b0;
    @(negedge clk);
    check("ready_same_cycle", valid, 1);
    @(negedge clk);
    check("ready_next_cycle", valid, 0);
    idle(C);

    // reset mid-frame while a frame is held
    set_ready(1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    idle(C);
    check("pre_rst_valid", valid, 1);
    check("pre_rst_data", data_out, 8'h77);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_data", data_out, 0);
    check("midrst_parity", parity_out, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovr", overrun, 0);
    if (m_held) begin
      exp_n--;
      m_held = 1'b0;
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    idle(2 * C);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(2 * C);
    check("post_rst_data", got_mem[got_n-1], {1'b0, 8'h81});

    // back-to-back with a single stop bit
    n0 = got_n;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(2 * C);
    check("b2b_frames", got_n - n0, 2);

    // randomized frames, occasional bad stop, random gaps
    for (int k = 0; k < 20; k++) begin
      d  = 8'($urandom);
      p  = 1'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, p, st);
      if (!st) idle(C * $urandom_range(1, 2));
      else     idle($urandom_range(0, 2 * C));
    end
    idle(3 * C);

    check("total_frames", got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++)
      check($sformatf("frame_%0d", i), got_mem[i], exp_mem[i]);
    check("total_ferr", ferr_cnt, exp_ferr);
    check("total_ovr", ovr_cnt, exp_ovr);
    check("ferr_ovr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
